fpu_rob_issuer: RTL and testbench

- Initiator and collector in front of the FPNew wrapper.
- Accepts FPU requests in order from a core-side port and assigns each one a free tag. It issues the request to the FPU request handshake, then captures results that may return out of order on the FPU result handshake, keyed by tag.
- Releases results strictly in issue order on a response port.
- Drives the FPU flush and derives a busy indication.

---
 rtl/fpu_rob_issuer.sv | 135 +++++++++++++
 tb/tb_fpu_rob_issuer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_rob_issuer.sv
// Tags FPU requests in order, collects out-of-order FPU results by tag,
// and releases them to the core strictly in issue order.
module fpu_rob_issuer #(
    parameter  int FLEN      = 64,
    parameter  int REQ_WIDTH = 208,
    parameter  int DEPTH     = 4,
    localparam int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [REQ_WIDTH-1:0] req_payload_i,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic [REQ_WIDTH-1:0] fpu_payload_o,
    output logic [TAG_WIDTH-1:0] fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [FLEN-1:0]      fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_WIDTH-1:0] fpu_tag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [FLEN-1:0]      rsp_result_o,
    output logic [4:0]           rsp_status_o,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 spurious_o
);

    localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0]     alloc_q, alloc_d;
    logic [DEPTH-1:0]     done_q, done_d;
    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [TAG_WIDTH:0]   count_q, count_d;
    logic                 spur_q, spur_d;

    logic [FLEN-1:0] res_q [DEPTH];
    logic [4:0]      st_q  [DEPTH];

    logic full;
    logic issue;
    logic retire;
    logic cap_hit;

    assign full = (count_q == FULL_CNT);

    // Combinational handshake outputs are also held quiet while in reset.
    assign req_ready_o    = fpu_in_ready_i & ~full & ~flush_i & ~rst_i;
    assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i & ~rst_i;
    assign fpu_payload_o  = req_payload_i;
    assign fpu_tag_o      = tail_q;
    assign fpu_flush_o    = flush_i & ~rst_i;

    assign fpu_out_ready_o = 1'b1;

    assign rsp_valid_o  = alloc_q[head_q] & done_q[head_q] & ~flush_i;
    assign rsp_result_o = res_q[head_q];
    assign rsp_status_o = st_q[head_q];

    assign busy_o     = (count_q != '0);
    assign spurious_o = spur_q;

    assign issue   = req_valid_i & req_ready_o;
    assign retire  = rsp_valid_o & rsp_ready_i;
    assign cap_hit = fpu_out_valid_i & ~flush_i
                   & alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        spur_d  = 1'b0;
        if (flush_i) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cap_hit) begin
                done_d[fpu_tag_i] = 1'b1;
            end
            spur_d = fpu_out_valid_i & ~cap_hit;
            if (retire) begin
                alloc_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (issue) begin
                alloc_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            unique case ({issue, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            spur_q  <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            spur_q  <= spur_d;
        end
    end

    // Payload storage carries no reset; it is only read once done is set.
    always_ff @(posedge clk_i) begin
        if (cap_hit) begin
            res_q[fpu_tag_i] <= fpu_result_i;
            st_q[fpu_tag_i]  <= fpu_status_i;
        end
    end

endmodule

// File: tb/tb_fpu_rob_issuer.sv
// Randomized scoreboard bench for fpu_rob_issuer: the bench plays both
// core and FPU, and a queue model predicts every handshake output.
module tb_fpu_rob_issuer;

    localparam int FLEN = 64;
    localparam int RW   = 208;
    localparam int D    = 4;
    localparam int TW   = 2;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [RW-1:0]   req_payload_i = '0;
    logic            fpu_in_valid_o;
    logic            fpu_in_ready_i = 1'b1;
    logic [RW-1:0]   fpu_payload_o;
    logic [TW-1:0]   fpu_tag_o;
    logic            fpu_flush_o;
    logic            fpu_out_valid_i = 1'b0;
    logic            fpu_out_ready_o;
    logic [FLEN-1:0] fpu_result_i = '0;
    logic [4:0]      fpu_status_i = '0;
    logic [TW-1:0]   fpu_tag_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [FLEN-1:0] rsp_result_o;
    logic [4:0]      rsp_status_o;
    logic            flush_i = 1'b0;
    logic            busy_o;
    logic            spurious_o;

    always #5 clk = ~clk;

    fpu_rob_issuer #(.FLEN(FLEN), .REQ_WIDTH(RW), .DEPTH(D)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_payload_i   (req_payload_i),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .fpu_payload_o   (fpu_payload_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_flush_o     (fpu_flush_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_tag_i       (fpu_tag_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_status_o    (rsp_status_o),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
        .spurious_o      (spurious_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [FLEN-1:0] res;
        logic [4:0]      st;
    } rsp_t;

    // Scoreboard of responses in issue order, plus the ROB view of the core.
    rsp_t exp_q[$];
    int   m_order[$];
    bit   m_done[D];
    int   m_tail = 0;
    bit   m_spur = 1'b0;

    // FPU side: results issued but not yet returned.
    bit   fl_v[D];
    rsp_t fl_d[D];

    function automatic bit in_order(int t);
        foreach (m_order[i]) if (m_order[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_order.delete();
        exp_q.delete();
        m_tail = 0;
        m_spur = 1'b0;
        foreach (m_done[i]) m_done[i] = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        bit full, fire, mval, hs, hit;
        if (rst_i) begin
            model_clear();
        end else begin
            full = (m_order.size() == D);
            chk("req_ready", RW'(req_ready_o),
                RW'(fpu_in_ready_i & !full & !flush_i));
            chk("fpu_in_valid", RW'(fpu_in_valid_o),
                RW'(req_valid_i & !full & !flush_i));
            chk("fpu_payload", fpu_payload_o, req_payload_i);
            chk("fpu_tag", RW'(fpu_tag_o), RW'(m_tail));
            chk("fpu_flush", RW'(fpu_flush_o), RW'(flush_i));
            chk("fpu_out_ready", RW'(fpu_out_ready_o), RW'(1'b1));
            chk("busy", RW'(busy_o), RW'(m_order.size() != 0));
            chk("spurious", RW'(spurious_o), RW'(m_spur));
            mval = !flush_i && m_order.size() > 0 && m_done[m_order[0]];
            chk("rsp_valid", RW'(rsp_valid_o), RW'(mval));
            if (mval) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_scoreboard_empty", RW'(1'b1), RW'(1'b0));
                end else begin
                    chk("rsp_result", RW'(rsp_result_o), RW'(exp_q[0].res));
                    chk("rsp_status", RW'(rsp_status_o), RW'(exp_q[0].st));
                end
            end
            hs   = mval && rsp_ready_i;
            fire = req_valid_i && fpu_in_ready_i && !full && !flush_i;
            if (flush_i) begin
                model_clear();
            end else begin
                hit = fpu_out_valid_i && in_order(int'(fpu_tag_i))
                      && !m_done[fpu_tag_i];
                if (hit) m_done[fpu_tag_i] = 1'b1;
                m_spur = fpu_out_valid_i && !hit;
                if (hs) begin
                    m_done[m_order[0]] = 1'b0;
                    void'(m_order.pop_front());
                    void'(exp_q.pop_front());
                end
                if (fire) begin
                    m_order.push_back(m_tail);
                    m_done[m_tail] = 1'b0;
                    m_tail = (m_tail + 1) % D;
                end
            end
        end
    end

    task automatic drive(int preq, int prdy, int pbeat,
                         int prsp, int pfl, int pspur);
        int t;
        int off;
        rsp_t r;
        @(posedge clk);
        #1;
        flush_i        = ($urandom_range(99) < pfl);
        req_valid_i    = ($urandom_range(99) < preq);
        fpu_in_ready_i = ($urandom_range(99) < prdy);
        rsp_ready_i    = ($urandom_range(99) < prsp);
        for (int i = 0; i < RW; i++) req_payload_i[i] = 1'($urandom_range(1));
        fpu_out_valid_i = 1'b0;
        fpu_tag_i       = TW'($urandom_range(D-1));
        fpu_result_i    = {$urandom(), $urandom()};
        fpu_status_i    = 5'($urandom_range(31));
        if ($urandom_range(99) < pspur) begin
            t = $urandom_range(D-1);
            if (!fl_v[t]) begin
                fpu_out_valid_i = 1'b1;
                fpu_tag_i       = TW'(t);
            end
        end else if ($urandom_range(99) < pbeat) begin
            off = $urandom_range(D-1);
            for (int k = 0; k < D; k++) begin
                t = (off + k) % D;
                if (fl_v[t] && !fpu_out_valid_i) begin
                    fpu_out_valid_i = 1'b1;
                    fpu_tag_i       = TW'(t);
                    fpu_result_i    = fl_d[t].res;
                    fpu_status_i    = fl_d[t].st;
                    fl_v[t]         = 1'b0;
                end
            end
        end
        if (req_valid_i && fpu_in_ready_i && m_order.size() < D && !flush_i) begin
            r.res = {$urandom(), $urandom()};
            r.st  = 5'($urandom_range(31));
            exp_q.push_back(r);
            fl_v[m_tail] = 1'b1;
            fl_d[m_tail] = r;
        end
        if (flush_i) foreach (fl_v[i]) fl_v[i] = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_req_ready", RW'(req_ready_o), RW'(1'b0));
        chk("rst_fpu_in_valid", RW'(fpu_in_valid_o), RW'(1'b0));
        chk("rst_rsp_valid", RW'(rsp_valid_o), RW'(1'b0));
        chk("rst_busy", RW'(busy_o), RW'(1'b0));
        chk("rst_fpu_flush", RW'(fpu_flush_o), RW'(1'b0));
        chk("rst_fpu_out_ready", RW'(fpu_out_ready_o), RW'(1'b1));
        chk("rst_fpu_tag", RW'(fpu_tag_o), RW'(0));
        chk("rst_spurious", RW'(spurious_o), RW'(1'b0));
    endtask

    task automatic idle_inputs();
        req_valid_i     = 1'b0;
        fpu_in_ready_i  = 1'b1;
        fpu_out_valid_i = 1'b0;
        rsp_ready_i     = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        idle_inputs();
        #2;
        rst_i = 1'b1;
        #1;
        check_reset();
        foreach (fl_v[i]) fl_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        foreach (fl_v[i]) fl_v[i] = 1'b0;
        idle_inputs();
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        repeat (400) drive(70, 80, 50, 70, 0, 0);
        repeat (300) drive(90, 100, 5, 30, 0, 0);
        repeat (300) drive(80, 90, 60, 10, 0, 0);
        repeat (400) drive(70, 80, 50, 60, 3, 5);
        repeat (40)  drive(90, 100, 10, 20, 0, 0);
        reset_mid();
        repeat (600) drive(75, 85, 45, 55, 2, 4);
        reset_mid();
        repeat (300) drive(60, 70, 70, 80, 1, 3);

        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
